// File: rtl/sensor_cmd_tx.sv
// sensor_cmd_tx
// UART (8N1) command transmitter for the wireless inertial sensor link. Each
// accepted command becomes a sequence of 5-byte frames: 0xFF 0xAA b2 b3 b4.
// When cmd_save is set, the command frame is wrapped between an unlock frame
// (69 88 B5) and a save frame (00 00 00) so the setting persists in the sensor.
// Every frame is followed by GAP_BITS idle bit-times.
//
// Ports:
//   clk_uart    in   1  only clock, rising edge
//   rst         in   1  synchronous active-high reset
//   cmd_valid   in   1  command offered
//   cmd_ready   out  1  block can accept a command (idle and not in reset)
//   cmd_addr    in   8  sensor register address, captured on transfer
//   cmd_data    in  16  register value (low byte sent first), captured on transfer
//   cmd_save    in   1  wrap command in unlock/save frames, captured on transfer
//   busy        out  1  a sequence is in progress
//   frames_sent out  8  completed frame count, wraps 255 -> 0
//   wireless_rx out  1  registered serial line, idles high
//   state_dbg   out  3  current FSM state encoding
//
// Handshake: a command transfers on a cycle where cmd_valid && cmd_ready.
// cmd_valid while not ready is dropped, not queued.

module sensor_cmd_tx #(
    parameter int CLKS_PER_BIT = 104,
    parameter int GAP_BITS     = 4
) (
    input  logic        clk_uart,
    input  logic        rst,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [7:0]  cmd_addr,
    input  logic [15:0] cmd_data,
    input  logic        cmd_save,
    output logic        busy,
    output logic [7:0]  frames_sent,
    output logic        wireless_rx,
    output logic [2:0]  state_dbg
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam int GAP_W = $clog2(GAP_BITS + 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_START = 3'd1,
        S_DATA  = 3'd2,
        S_STOP  = 3'd3,
        S_GAP   = 3'd4
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   bit_cnt_q, bit_cnt_d;
    logic [2:0]         bit_idx_q, bit_idx_d;
    logic [2:0]         byte_idx_q, byte_idx_d;
    logic [1:0]         frame_idx_q, frame_idx_d;
    logic [GAP_W-1:0]   gap_cnt_q, gap_cnt_d;
    logic [7:0]         addr_q;
    logic [15:0]        data_q;
    logic               save_q;
    logic [7:0]         frames_q;
    logic               line_q, line_d;
    logic               capture;
    logic               frame_done;
    logic               tick;
    logic [1:0]         last_frame;
    logic [7:0]         tx_byte;

    assign tick       = (bit_cnt_q == CNT_W'(CLKS_PER_BIT - 1));
    assign last_frame = save_q ? 2'd2 : 2'd0;

    // Next-state and counter logic.
    always_comb begin
        state_d     = state_q;
        bit_idx_d   = bit_idx_q;
        byte_idx_d  = byte_idx_q;
        frame_idx_d = frame_idx_q;
        gap_cnt_d   = gap_cnt_q;
        capture     = 1'b0;
        frame_done  = 1'b0;
        // Bit-time counter free-runs through every non-idle state.
        if (state_q == S_IDLE || tick) begin
            bit_cnt_d = '0;
        end else begin
            bit_cnt_d = bit_cnt_q + CNT_W'(1);
        end

        case (state_q)
            S_IDLE: begin
                if (cmd_valid) begin
                    state_d     = S_START;
                    capture     = 1'b1;
                    byte_idx_d  = 3'd0;
                    frame_idx_d = 2'd0;
                end
            end
            S_START: begin
                if (tick) begin
                    state_d   = S_DATA;
                    bit_idx_d = 3'd0;
                end
            end
            S_DATA: begin
                if (tick) begin
                    if (bit_idx_q == 3'd7) begin
                        state_d = S_STOP;
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                    end
                end
            end
            S_STOP: begin
                if (tick) begin
                    if (byte_idx_q == 3'd4) begin
                        state_d    = S_GAP;
                        gap_cnt_d  = '0;
                        frame_done = 1'b1;
                    end else begin
                        state_d    = S_START;
                        byte_idx_d = byte_idx_q + 3'd1;
                    end
                end
            end
            S_GAP: begin
                if (tick) begin
                    if (gap_cnt_q == GAP_W'(GAP_BITS - 1)) begin
                        if (frame_idx_q != last_frame) begin
                            state_d     = S_START;
                            frame_idx_d = frame_idx_q + 2'd1;
                            byte_idx_d  = 3'd0;
                        end else begin
                            state_d = S_IDLE;
                        end
                    end else begin
                        gap_cnt_d = gap_cnt_q + GAP_W'(1);
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Byte about to be on the line. Uses next-state indices because the line
    // is registered; captured fields are already stable whenever DATA is next.
    always_comb begin
        tx_byte = 8'h00;
        case (byte_idx_d)
            3'd0: tx_byte = 8'hFF;
            3'd1: tx_byte = 8'hAA;
            default: begin
                if (save_q && frame_idx_d == 2'd0) begin
                    case (byte_idx_d)
                        3'd2:    tx_byte = 8'h69;
                        3'd3:    tx_byte = 8'h88;
                        default: tx_byte = 8'hB5;
                    endcase
                end else if (save_q && frame_idx_d == 2'd2) begin
                    tx_byte = 8'h00;
                end else begin
                    case (byte_idx_d)
                        3'd2:    tx_byte = addr_q;
                        3'd3:    tx_byte = data_q[7:0];
                        default: tx_byte = data_q[15:8];
                    endcase
                end
            end
        endcase
    end

    always_comb begin
        line_d = 1'b1;
        case (state_d)
            S_START: line_d = 1'b0;
            S_DATA:  line_d = tx_byte[bit_idx_d];
            default: line_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk_uart) begin
        if (rst) begin
            state_q     <= S_IDLE;
            bit_cnt_q   <= '0;
            bit_idx_q   <= 3'd0;
            byte_idx_q  <= 3'd0;
            frame_idx_q <= 2'd0;
            gap_cnt_q   <= '0;
            frames_q    <= 8'd0;
            line_q      <= 1'b1;
        end else begin
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            bit_idx_q   <= bit_idx_d;
            byte_idx_q  <= byte_idx_d;
            frame_idx_q <= frame_idx_d;
            gap_cnt_q   <= gap_cnt_d;
            line_q      <= line_d;
            if (frame_done) begin
                frames_q <= frames_q + 8'd1;
            end
        end
    end

    always_ff @(posedge clk_uart) begin
        if (!rst && capture) begin
            addr_q <= cmd_addr;
            data_q <= cmd_data;
            save_q <= cmd_save;
        end
    end

    assign cmd_ready   = (state_q == S_IDLE) && !rst;
    assign busy        = (state_q != S_IDLE);
    assign frames_sent = frames_q;
    assign wireless_rx = line_q;
    assign state_dbg   = state_q;

endmodule

// File: tb/tb_sensor_cmd_tx.sv
// Directed bench for sensor_cmd_tx with CLKS_PER_BIT = 4, GAP_BITS = 2.
// One frame plus its gap is (50+2)*4 = 208 cycles. The line is logged one
// sample per cycle starting at T+1 (index 0), so bit j of byte k of frame f
// sits at indices f*208 + (10k+j)*4 .. +3.

module tb_sensor_cmd_tx;

    localparam int N     = 4;
    localparam int G     = 2;
    localparam int FRAME = (50 + G) * N;

    logic        clk_uart = 1'b0;
    logic        rst;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [7:0]  cmd_addr;
    logic [15:0] cmd_data;
    logic        cmd_save;
    logic        busy;
    logic [7:0]  frames_sent;
    logic        wireless_rx;
    logic [2:0]  state_dbg;

    int tests_run    = 0;
    int tests_failed = 0;

    logic        line_log  [0:1023];
    logic        busy_log  [0:1023];
    logic        ready_log [0:1023];
    logic [7:0]  addr_drv  [0:1023];
    logic [15:0] data_drv  [0:1023];

    sensor_cmd_tx #(.CLKS_PER_BIT(N), .GAP_BITS(G)) dut (
        .clk_uart    (clk_uart),
        .rst         (rst),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_addr    (cmd_addr),
        .cmd_data    (cmd_data),
        .cmd_save    (cmd_save),
        .busy        (busy),
        .frames_sent (frames_sent),
        .wireless_rx (wireless_rx),
        .state_dbg   (state_dbg)
    );

    // Clock / watchdog
    always #5 clk_uart = ~clk_uart;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not reach the end (observed timeout, required finish)");
        $fatal(1, "watchdog expired");
    end

    // Driver tasks
    task automatic step();
        @(posedge clk_uart);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Offer a command in the current cycle (T); returns in cycle T+1.
    task automatic send_cmd(input logic [7:0] addr, input logic [15:0] data, input logic save);
        check("ready_at_transfer", {31'd0, cmd_ready}, 32'd1);
        cmd_valid = 1'b1;
        cmd_addr  = addr;
        cmd_data  = data;
        cmd_save  = save;
        step();
        cmd_valid = 1'b0;
    endtask

    // Log n cycles. Indices up to hold_last keep cmd_valid high with fresh
    // random addr/data, remembering what was driven.
    task automatic record(input int n, input int hold_last);
        for (int i = 0; i < n; i++) begin
            line_log[i]  = wireless_rx;
            busy_log[i]  = busy;
            ready_log[i] = cmd_ready;
            if (i <= hold_last) begin
                cmd_valid   = 1'b1;
                cmd_addr    = 8'($urandom_range(0, 255));
                cmd_data    = 16'($urandom_range(0, 65535));
                cmd_save    = 1'b0;
                addr_drv[i] = cmd_addr;
                data_drv[i] = cmd_data;
            end else begin
                cmd_valid = 1'b0;
            end
            step();
        end
        cmd_valid = 1'b0;
    endtask

    // 10-bit character {stop, data[7:0], start}; a bit whose N samples
    // disagree decodes as x.
    function automatic logic [9:0] decode(input int base);
        logic [9:0] w;
        logic       v;
        for (int b = 0; b < 10; b++) begin
            v = line_log[base + b * N];
            for (int s = 1; s < N; s++) begin
                if (line_log[base + b * N + s] !== v) v = 1'bx;
            end
            w[b] = v;
        end
        return w;
    endfunction

    task automatic check_frame(input string tag, input int base,
                               input logic [7:0] b2, input logic [7:0] b3, input logic [7:0] b4);
        logic [7:0] exp_b [5];
        exp_b[0] = 8'hFF;
        exp_b[1] = 8'hAA;
        exp_b[2] = b2;
        exp_b[3] = b3;
        exp_b[4] = b4;
        for (int k = 0; k < 5; k++) begin
            check($sformatf("%s_byte%0d", tag, k), {22'd0, decode(base + k * 10 * N)},
                  {22'd0, 1'b1, exp_b[k], 1'b0});
        end
    endtask

    function automatic logic all_high(input int lo, input int hi);
        logic r;
        r = 1'b1;
        for (int i = lo; i <= hi; i++) begin
            if (line_log[i] !== 1'b1) r = 1'b0;
        end
        return r;
    endfunction

    // Directed sequence
    initial begin
        logic ok;
        logic prev;

        rst       = 1'b1;
        cmd_valid = 1'b0;
        cmd_addr  = 8'h00;
        cmd_data  = 16'h0000;
        cmd_save  = 1'b0;
        step();
        step();
        step();
        check("ready_in_reset", {31'd0, cmd_ready}, 32'd0);
        rst = 1'b0;
        step();
        check("reset_ready", {31'd0, cmd_ready}, 32'd1);
        check("reset_line", {31'd0, wireless_rx}, 32'd1);
        check("reset_busy", {31'd0, busy}, 32'd0);
        check("reset_frames", {24'd0, frames_sent}, 32'd0);
        check("reset_state", {29'd0, state_dbg}, 32'd0);

        // Single frame
        send_cmd(8'h03, 16'h0108, 1'b0);
        record(FRAME + 1, -1);
        check_frame("single", 0, 8'h03, 8'h08, 8'h01);
        check("single_busy_first", {31'd0, busy_log[0]}, 32'd1);
        check("single_busy_last", {31'd0, busy_log[FRAME - 1]}, 32'd1);
        check("single_busy_after", {31'd0, busy_log[FRAME]}, 32'd0);
        check("single_ready_early", {31'd0, ready_log[FRAME - 1]}, 32'd0);
        check("single_ready_back", {31'd0, ready_log[FRAME]}, 32'd1);
        check("single_gap_high", {31'd0, all_high(200, FRAME)}, 32'd1);
        check("single_frames", {24'd0, frames_sent}, 32'd1);

        // Save sequence
        send_cmd(8'h1F, 16'h0006, 1'b1);
        record(3 * FRAME + 1, -1);
        check_frame("save_unlock", 0, 8'h69, 8'h88, 8'hB5);
        check_frame("save_cmd", FRAME, 8'h1F, 8'h06, 8'h00);
        check_frame("save_save", 2 * FRAME, 8'h00, 8'h00, 8'h00);
        check("save_busy_last", {31'd0, busy_log[3 * FRAME - 1]}, 32'd1);
        check("save_busy_after", {31'd0, busy_log[3 * FRAME]}, 32'd0);
        check("save_ready_early", {31'd0, ready_log[3 * FRAME - 1]}, 32'd0);
        check("save_ready_back", {31'd0, ready_log[3 * FRAME]}, 32'd1);
        check("save_frames", {24'd0, frames_sent}, 32'd4);

        // Command held while busy: only the values at T count, and the next
        // transfer lands at T+209 (index 208) with its start bit at T+210.
        send_cmd(8'h55, 16'h1234, 1'b0);
        record(2 * FRAME + 2, FRAME);
        check_frame("hold_first", 0, 8'h55, 8'h34, 8'h12);
        check("hold_idle_at_transfer", {31'd0, line_log[FRAME]}, 32'd1);
        check("hold_second_start", {31'd0, line_log[FRAME + 1]}, 32'd0);
        check_frame("hold_second", FRAME + 1, addr_drv[FRAME], data_drv[FRAME][7:0], data_drv[FRAME][15:8]);
        check("hold_ready_end", {31'd0, ready_log[2 * FRAME + 1]}, 32'd1);
        check("hold_frames", {24'd0, frames_sent}, 32'd6);

        // Bit timing with alternating data
        send_cmd(8'h00, 16'h5555, 1'b0);
        record(FRAME + 1, -1);
        ok   = 1'b1;
        prev = 1'b1;
        for (int i = 0; i <= FRAME; i++) begin
            if (line_log[i] !== prev) begin
                if ((i % N) != 0) ok = 1'b0;
                prev = line_log[i];
            end
        end
        check("timing_edges_aligned", {31'd0, ok}, 32'd1);
        check("timing_start_width",
              {27'd0, line_log[4], line_log[3], line_log[2], line_log[1], line_log[0]}, 32'h10);
        check_frame("timing", 0, 8'h00, 8'h55, 8'h55);

        // Reset in byte 2, bit 4 (indices 96..99); assert at index 98.
        send_cmd(8'h03, 16'h0108, 1'b0);
        record(98, -1);
        rst = 1'b1;
        #1;
        check("midreset_ready_low", {31'd0, cmd_ready}, 32'd0);
        step();
        rst = 1'b0;
        #1;
        check("midreset_line", {31'd0, wireless_rx}, 32'd1);
        check("midreset_busy", {31'd0, busy}, 32'd0);
        check("midreset_frames", {24'd0, frames_sent}, 32'd0);
        check("midreset_ready", {31'd0, cmd_ready}, 32'd1);
        record(250, -1);
        check("midreset_line_quiet", {31'd0, all_high(0, 249)}, 32'd1);
        send_cmd(8'h42, 16'hBEEF, 1'b0);
        record(FRAME + 1, -1);
        check_frame("after_reset", 0, 8'h42, 8'hEF, 8'hBE);
        check("after_reset_frames", {24'd0, frames_sent}, 32'd1);

        // Counter wrap: 254 more frames reach 255, one more wraps to 0.
        ok = 1'b1;
        for (int c = 0; c < 254; c++) begin
            send_cmd(8'(c), 16'(c * 7), 1'b0);
            record(FRAME + 1, -1);
            if (!all_high(200, FRAME) || ready_log[FRAME] !== 1'b1 ||
                line_log[0] !== 1'b0 || line_log[199] !== 1'b1) ok = 1'b0;
        end
        check("wrap_gaps_and_ready", {31'd0, ok}, 32'd1);
        check("wrap_frames_255", {24'd0, frames_sent}, 32'd255);
        send_cmd(8'h7E, 16'hA55A, 1'b0);
        record(FRAME + 1, -1);
        check_frame("wrap_last", 0, 8'h7E, 8'h5A, 8'hA5);
        check("wrap_frames_0", {24'd0, frames_sent}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/sensor_cmd_tx.md
# sensor_cmd_tx

UART command transmitter for the wireless inertial sensor link, running in the `clk_uart` domain. It drives the `wireless_rx` line toward the wireless module and sends sensor configuration frames: `0xFF 0xAA addr dataL dataH`. This is the host-to-sensor direction of the link whose sensor-to-host frames the `sensor` block decodes. Optionally, a command is wrapped in an unlock/save sequence so the setting persists in the sensor.

## Interface
Parameters:
- `CLKS_PER_BIT`, default 104: `clk_uart` cycles per UART bit. Must be ≥ 2.
- `GAP_BITS`, default 4: idle bit-times inserted after every frame. Must be ≥ 1.

Ports:
- `clk_uart`  in  1: the only clock; all logic runs on its rising edge.
- `rst`  in  1: synchronous, active-high reset.
- `cmd_valid`  in  1: a command is offered.
- `cmd_ready`  out  1: the block can accept a command. Transfer occurs on a cycle where `cmd_valid && cmd_ready`.
- `cmd_addr`  in  8: sensor register address. Sampled on transfer.
- `cmd_data`  in  16: register value, sent low byte first. Sampled on transfer.
- `cmd_save`  in  1: if 1, send the sequence unlock, command, save. If 0, send the command frame only. Sampled on transfer.
- `busy`  out  1: a sequence is in progress.
- `frames_sent`  out  8: count of completed frames; wraps 255 → 0.
- `wireless_rx`  out  1: serial data to the wireless module. Idle level is high.

## Operation
- **Byte format:** 8N1. Start bit 0, then data bits LSB first, then stop bit 1. Each bit is held exactly `CLKS_PER_BIT` cycles.
- **Frame format:** 5 bytes, sent back to back with no idle between bytes: `0xFF`, `0xAA`, b2, b3, b4.
- **Frames in a sequence:**
  - Unlock frame: b2 = `0x69`, b3 = `0x88`, b4 = `0xB5`.
  - Command frame: b2 = `cmd_addr`, b3 = `cmd_data[7:0]`, b4 = `cmd_data[15:8]`.
  - Save frame: b2 = `0x00`, b3 = `0x00`, b4 = `0x00`.
  - The sequence is 1 frame when `cmd_save` = 0, or 3 frames (unlock, command, save) when `cmd_save` = 1.
- **State machine:** states IDLE, START, DATA, STOP, GAP.
  - IDLE → START on transfer.
  - START → DATA after 1 bit-time.
  - DATA → STOP after 8 bit-times.
  - STOP → START when the byte index is < 4, else STOP → GAP.
  - GAP → START (next frame) when frames remain in the sequence, else GAP → IDLE.
- **Counters:**
  - Bit-time counter: `$clog2(CLKS_PER_BIT)` bits, counts 0 … `CLKS_PER_BIT`−1.
  - Bit index: 0–7.
  - Byte index: 0–4.
  - Frame index: 0–2.
  - Gap counter: counts `GAP_BITS` bit-times.
- **Captured fields:** `cmd_addr`, `cmd_data` and `cmd_save` are captured into registers on transfer. Input changes while `busy` = 1 have no effect.
- **`cmd_ready`:** equals (state == IDLE) && !`rst`. `cmd_valid` while not ready is ignored and is not queued.
- **`frames_sent`:** increments by 1 on the last cycle of each frame's final stop bit.
- **Reset:** applies from any state, including mid-bit.
  - On the following cycle: `wireless_rx` = 1, `busy` = 0, `frames_sent` = 0, state = IDLE.
  - A partial byte is truncated and is never resumed.
  - `cmd_ready` = 0 while `rst` is high, and 1 on the first cycle after `rst` falls.

## Timing
Let N = `CLKS_PER_BIT`, G = `GAP_BITS`, and T = the transfer cycle.
- `wireless_rx` is registered. On cycle T it is still 1.
- Bit j of byte k of frame f is driven on cycles T+1 + f·(50+G)·N + (10k+j)·N through the next N−1 cycles.
- The gap after frame f occupies (G·N) cycles following that frame's last stop cycle. `wireless_rx` = 1 throughout the gap.
- `busy` = 1 from T+1 through T + F·(50+G)·N, where F = 1 or 3.
- IDLE is re-entered on cycle T + F·(50+G)·N + 1, and `cmd_ready` = 1 on that cycle.
- Back-to-back commands:
  - The earliest next transfer is on that same cycle.
  - Minimum command spacing is therefore F·(50+G)·N + 1 cycles.
- Each bit is exactly N cycles; there is no jitter and no fractional-baud accumulation.

## Test plan
All scenarios use N = 4, G = 2.
- **Single frame:** `cmd_save` = 0, addr = `0x03`, data = `0x0108`.
  - The line decodes to `FF AA 03 08 01`.
  - `busy` is high for cycles T+1 … T+208.
  - `cmd_ready` returns to 1 at T+209.
  - `frames_sent` = 1.
- **Save sequence:** `cmd_save` = 1, addr = `0x1F`, data = `0x0006`.
  - The line decodes to `FF AA 69 88 B5`, then `FF AA 1F 06 00`, then `FF AA 00 00 00`.
  - Each frame start is 208 cycles apart.
  - `cmd_ready` returns to 1 at T+625.
  - `frames_sent` = 3.
- **Ignored command while busy:** hold `cmd_valid` high with changing addr/data during a frame.
  - The frame content matches the values captured at T.
  - A second frame starts only after transfer at T+209, with start bit at T+210.
- **Reset mid-byte:** assert `rst` for 1 cycle in the middle of byte 2, bit 4.
  - Next cycle: `wireless_rx` = 1, `busy` = 0, `frames_sent` = 0.
  - No further low bits appear.
  - A subsequent command produces a complete, correct frame.
- **Counter wrap:** issue 256 single-frame commands.
  - `frames_sent` reads 255, then 0.
  - Line idle is high between frames for exactly 8 cycles after each stop bit, plus any valid-wait time.
- **Bit timing:** for `cmd_data` = `0x5555`, measure every line transition.
  - All intervals are multiples of 4 cycles.
  - The start-bit low lasts exactly 4 cycles.
